regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, 1, when 1 register 0 is hardwired to zero and never pending.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 addr1, addr2  input  ADDR_W  read port addresses.
REQ-008 data1, data2  output  DATA_W  read port data, combinational.
REQ-009 busy1, busy2  output  1  pending (scoreboard) bit of addr1/addr2, combinational.
REQ-010 wr  input  1  write enable.
REQ-011 addr3  input  ADDR_W  write address.
REQ-012 data3  input  DATA_W  write data.
REQ-013 claim  input  1  mark register claim_addr as pending (result in flight).
REQ-014 claim_addr  input  ADDR_W  register to claim.
REQ-015 clr_req  input  1  request a full sequential clear of all registers.
REQ-016 ready  output  1  high when state is RUN.

Function
REQ-017 FSM states SHALL be CLEAR and RUN; CLEAR writes zero to register clr_cnt each cycle, clr_cnt increments from 0.
REQ-018 CLEAR -> RUN SHALL occur on the cycle after clr_cnt = DEPTH-1 is written; a full clear takes exactly DEPTH cycles.
REQ-019 RUN -> CLEAR SHALL occur on the cycle after clr_req=1 sampled in RUN, with clr_cnt reloaded to 0; clr_req in CLEAR is ignored (no restart).
REQ-020 Entering CLEAR SHALL clear all pending bits in the same edge.
REQ-021 In CLEAR: data1/data2 = 0, busy1/busy2 = 0, wr and claim ignored.
REQ-022 In RUN, wr=1 SHALL write data3 to addr3 at the rising edge, except addr3=0 when ZERO_REG=1.
REQ-023 Read bypass: in RUN, if wr=1 and addrN = addr3 (and write not suppressed by REQ-022), dataN SHALL equal data3 in the same cycle; otherwise stored value.
REQ-024 With ZERO_REG=1, addrN=0 SHALL read 0 and busyN=0 regardless of wr/claim.
REQ-025 claim=1 in RUN SHALL set pending[claim_addr] at the edge; wr=1 in RUN SHALL clear pending[addr3].
REQ-026 Simultaneous claim and wr to the same address SHALL leave pending set (claim wins).
REQ-027 busyN SHALL be pending[addrN] masked by bypass: if wr=1 to addrN this cycle and no claim to addrN, busyN=0.
REQ-028 Simultaneous claim and wr to different addresses SHALL both take effect.
REQ-029 Read ports are independent; addr1=addr2 SHALL return identical data and busy.
REQ-030 Register contents SHALL be unaffected by reads; no read side effects.

Reset
REQ-031 reset=1 at a rising edge SHALL force state CLEAR, clr_cnt=0, all pending=0, ready=0 at the following cycle, overriding wr, claim, clr_req.
REQ-032 reset asserted mid-CLEAR SHALL restart the sweep from clr_cnt=0.
REQ-033 After reset deassertion ready SHALL rise exactly DEPTH cycles later; all registers read 0.
REQ-034 Register contents need not be defined before the first completed CLEAR; outputs SHALL read 0 until ready.

Verification
REQ-035 Reset pulse, ADDR_W=5 -> ready=0 for 32 cycles, ready=1 on cycle 33, reads of all addresses return 0.
REQ-036 RUN: write 0xDEADBEEF to reg 7 with addr1=7 same cycle -> data1=0xDEADBEEF combinationally; next cycle, wr=0 -> data1 still 0xDEADBEEF.
REQ-037 ZERO_REG=1: wr=1 addr3=0 data3=0x12345678, claim_addr=0 -> data1=0, busy1=0 at addr1=0 in that and later cycles.
REQ-038 claim reg 5; next cycle addr1=5 -> busy1=1; wr reg 5 with 0xA5 -> busy1=0 and data1=0xA5 same cycle; claim+wr reg 5 same cycle -> busy1=1 next cycle.
REQ-039 RUN with pending bits and data in regs 3, 9; pulse clr_req -> ready=0 next cycle, busy1=0, after 32 cycles ready=1, regs 3, 9 read 0.
REQ-040 Assert reset at clr_cnt=10 mid-CLEAR -> ready rises exactly 32 cycles after reset deassertion; wr during CLEAR has no effect.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle for the scoreboarded register file: two read ports,
// one write port, a claim (pending-set) port, clear request and ready.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              busy1;
  logic              busy2;
  logic              wr;
  logic [ADDR_W-1:0] addr3;
  logic [DATA_W-1:0] data3;
  logic              claim;
  logic [ADDR_W-1:0] claim_addr;
  logic              clr_req;
  logic              ready;

  // Drives requests, observes read data / status
  modport master (
    output addr1, addr2, wr, addr3, data3, claim, claim_addr, clr_req,
    input  data1, data2, busy1, busy2, ready
  );

  // The register file itself
  modport slave (
    input  addr1, addr2, wr, addr3, data3, claim, claim_addr, clr_req,
    output data1, data2, busy1, busy2, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with a per-register pending (scoreboard) bit.
// Two combinational read ports with write bypass, one write port, one
// claim port. A sequential CLEAR sweep zeroes one register per cycle
// after reset or on request; outputs read 0 until the sweep finishes.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic              ready_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              claim_ok;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign run = (state_reg == RUN);

  // Writes and claims only count in RUN; register 0 is immune when hardwired
  assign wr_ok    = run && bus.wr    && !((ZERO_REG != 0) && (bus.addr3 == '0));
  assign claim_ok = run && bus.claim && !((ZERO_REG != 0) && (bus.claim_addr == '0));

  // Next pending bit per register: a write retires it, a claim sets it (claim wins)
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      assign pending_next[gi] = (pending_reg[gi] && !(wr_ok && (bus.addr3 == IDX)))
                              || (claim_ok && (bus.claim_addr == IDX));
    end
  endgenerate

  assign rd_addr[0] = bus.addr1;
  assign rd_addr[1] = bus.addr2;

  // Identical read ports: zero-register mask, write bypass, busy masked by a retiring write
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic zero_sel;
      logic hit_wr;
      logic hit_claim;
      assign zero_sel  = (ZERO_REG != 0) && (rd_addr[gi] == '0);
      assign hit_wr    = wr_ok && (bus.addr3 == rd_addr[gi]);
      assign hit_claim = claim_ok && (bus.claim_addr == rd_addr[gi]);
      assign rd_data[gi] = (!run || zero_sel) ? '0 :
                           hit_wr             ? bus.data3 : mem[rd_addr[gi]];
      assign rd_busy[gi] = run && !zero_sel && pending_reg[rd_addr[gi]]
                           && !(hit_wr && !hit_claim);
    end
  endgenerate

  assign bus.data1 = rd_data[0];
  assign bus.data2 = rd_data[1];
  assign bus.busy1 = rd_busy[0];
  assign bus.busy2 = rd_busy[1];
  assign bus.ready = ready_reg;

  // Control FSM: sweep counter, pending bits and ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      pending_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          pending_reg <= '0;
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg   <= RUN;
            clr_cnt_reg <= '0;
            ready_reg   <= 1'b1;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (bus.clr_req) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            pending_reg <= '0;
            ready_reg   <= 1'b0;
          end else begin
            pending_reg <= pending_next;
          end
        end
        default: begin
          state_reg   <= CLEAR;
          clr_cnt_reg <= '0;
          pending_reg <= '0;
          ready_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Storage: the sweep zeroes one entry per CLEAR cycle, RUN takes normal writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == CLEAR) begin
        mem[clr_cnt_reg] <= '0;
      end else if (wr_ok) begin
        mem[bus.addr3] <= bus.data3;
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset sweep, a table of single-cycle
// RUN vectors, then clear-request and mid-sweep reset sequences.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int applied     = 0;
  int miscompares = 0;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr3;
    logic [DATA_W-1:0] data3;
    logic              claim;
    logic [ADDR_W-1:0] claim_addr;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic              b1;
    logic              b2;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic wr, int a3, logic [31:0] d3, logic cl, int ca,
                              int a1, int a2, logic [31:0] e1, logic [31:0] e2,
                              logic eb1, logic eb2);
    vec_t v;
    v.wr = wr; v.addr3 = ADDR_W'(a3); v.data3 = d3;
    v.claim = cl; v.claim_addr = ADDR_W'(ca);
    v.addr1 = ADDR_W'(a1); v.addr2 = ADDR_W'(a2);
    v.d1 = e1; v.d2 = e2; v.b1 = eb1; v.b2 = eb2;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr = 1'b0; bus.addr3 = '0; bus.data3 = '0;
    bus.claim = 1'b0; bus.claim_addr = '0; bus.clr_req = 1'b0;
  endtask

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sweep of DEPTH cycles: ready low throughout, optional stray traffic, ready high after
  task automatic sweep_check(string tag);
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      if (i == 10) bus.clr_req = 1'b1;                // ignored during CLEAR
      if (i == 20) begin bus.wr = 1'b1; bus.addr3 = 5'd2; bus.data3 = 32'h0000_0B0B; end
      if (i == 25) begin
        bus.wr = 1'b1; bus.addr3 = 5'd3; bus.data3 = 32'h0000_0BAD;
        bus.claim = 1'b1; bus.claim_addr = 5'd9;
      end
      bus.addr1 = 5'd3; bus.addr2 = 5'd9;
      #2;
      check({tag, "_ready_low"}, {31'd0, bus.ready}, 32'd0);
      if (i == 25) begin
        check({tag, "_data1_clear"}, bus.data1, 32'd0);
        check({tag, "_busy2_clear"}, {31'd0, bus.busy2}, 32'd0);
      end
      step();
    end
    idle();
    #2;
    check({tag, "_ready_high"}, {31'd0, bus.ready}, 32'd1);
    $display("%s: sweep finished, ready=%0b", tag, bus.ready);
  endtask

  initial begin
    vecs[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 7, 0, 32'hDEADBEEF, 32'h0,        0, 0);
    vecs[2]  = mk(1, 0, 32'h12345678, 1, 0, 0, 0, 32'h0,        32'h0,        0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 0, 7, 32'h0,        32'hDEADBEEF, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        1, 5, 5, 5, 32'h0,        32'h0,        0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        0, 0, 5, 7, 32'h0,        32'hDEADBEEF, 1, 0);
    vecs[6]  = mk(1, 5, 32'hA5,       0, 0, 5, 5, 32'hA5,       32'hA5,       0, 0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 5, 0, 32'hA5,       32'h0,        0, 0);
    vecs[8]  = mk(1, 5, 32'h11,       1, 5, 5, 7, 32'h11,       32'hDEADBEEF, 0, 0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 5, 5, 32'h11,       32'h11,       1, 1);
    vecs[10] = mk(1, 3, 32'h33,       1, 9, 3, 9, 32'h33,       32'h0,        0, 0);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 3, 9, 32'h33,       32'h0,        0, 1);
    vecs[12] = mk(1, 9, 32'h99,       0, 0, 9, 5, 32'h99,       32'h11,       0, 1);
    vecs[13] = mk(1, 3, 32'h34,       1, 9, 9, 3, 32'h99,       32'h34,       0, 0);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 9, 9, 32'h99,       32'h99,       1, 1);
    vecs[15] = mk(1, 5, 32'h55,       1, 5, 5, 3, 32'h55,       32'h34,       1, 0);
    vecs[16] = mk(0, 0, 32'h0,        0, 0, 5, 0, 32'h55,       32'h0,        1, 0);

    // Reset pulse and initial sweep
    reset = 1'b1;
    idle();
    bus.addr1 = '0; bus.addr2 = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.addr1 = ADDR_W'(i);
      #2;
      check("reset_ready_low", {31'd0, bus.ready}, 32'd0);
      if (i == 5) check("reset_data1_gated", bus.data1, 32'd0);
      step();
    end
    #2;
    check("reset_ready_high", {31'd0, bus.ready}, 32'd1);
    $display("reset: ready=%0b after %0d cycles", bus.ready, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      bus.addr1 = ADDR_W'(a);
      bus.addr2 = ADDR_W'(DEPTH - 1 - a);
      #1;
      check("reset_zero_data1", bus.data1, 32'd0);
      check("reset_zero_busy2", {31'd0, bus.busy2}, 32'd0);
    end
    step();

    // Table of single-cycle RUN vectors
    for (int i = 0; i < 17; i++) begin
      bus.wr = vecs[i].wr; bus.addr3 = vecs[i].addr3; bus.data3 = vecs[i].data3;
      bus.claim = vecs[i].claim; bus.claim_addr = vecs[i].claim_addr;
      bus.clr_req = 1'b0;
      bus.addr1 = vecs[i].addr1; bus.addr2 = vecs[i].addr2;
      #2;
      applied++;
      $display("vec %0d: a1=%0d a2=%0d d1=%h d2=%h b1=%0b b2=%0b rdy=%0b",
               i, bus.addr1, bus.addr2, bus.data1, bus.data2, bus.busy1, bus.busy2, bus.ready);
      if ({bus.data1, bus.data2, bus.busy1, bus.busy2, bus.ready} !==
          {vecs[i].d1, vecs[i].d2, vecs[i].b1, vecs[i].b2, 1'b1}) begin
        miscompares++;
        $display("FAIL vec%0d: got %h/%h/%0b/%0b/%0b expected %h/%h/%0b/%0b/1", i,
                 bus.data1, bus.data2, bus.busy1, bus.busy2, bus.ready,
                 vecs[i].d1, vecs[i].d2, vecs[i].b1, vecs[i].b2);
      end
      step();
    end

    // Clear request with data in regs 3,9 and pending bits on 5,9
    idle();
    bus.addr1 = 5'd9; bus.addr2 = 5'd3;
    #2;
    check("pre_clr_busy1", {31'd0, bus.busy1}, 32'd1);
    check("pre_clr_data2", bus.data2, 32'h34);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    #2;
    check("clr_busy1", {31'd0, bus.busy1}, 32'd0);
    check("clr_data1", bus.data1, 32'd0);
    sweep_check("clr");
    bus.addr1 = 5'd3; bus.addr2 = 5'd9;
    #1;
    check("clr_reg3_zero", bus.data1, 32'd0);
    check("clr_reg9_zero", bus.data2, 32'd0);
    check("clr_busy9", {31'd0, bus.busy2}, 32'd0);
    bus.addr1 = 5'd2;
    #1;
    check("clr_reg2_zero", bus.data1, 32'd0);
    step();

    // Write reg 4, request clear, then reset at clr_cnt=10
    bus.wr = 1'b1; bus.addr3 = 5'd4; bus.data3 = 32'h44;
    step();
    idle();
    bus.addr1 = 5'd4;
    #1;
    check("reg4_written", bus.data1, 32'h44);
    bus.clr_req = 1'b1;
    step();
    idle();
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep_check("midrst");
    bus.addr1 = 5'd4; bus.addr2 = 5'd2;
    #1;
    check("midrst_reg4_zero", bus.data1, 32'd0);
    check("midrst_reg2_zero", bus.data2, 32'd0);
    bus.addr1 = 5'd3;
    #1;
    check("midrst_reg3_zero", bus.data1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
